// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants, state encodings and config type for the conv sequencer
package conv_pkg;

  localparam int BEAT_BYTES = 8;
  localparam int TAP_BEATS  = 2;
  localparam int N_WX       = 4;
  localparam int N_WY       = 4;
  localparam int ADDR_W     = 9;

  // One-hot-ish encodings so ostate can be decoded directly by software
  localparam logic [7:0] ST_IDLE   = 8'h00;
  localparam logic [7:0] ST_LD_KER = 8'h01;
  localparam logic [7:0] ST_LD_WIN = 8'h02;
  localparam logic [7:0] ST_MAC    = 8'h04;
  localparam logic [7:0] ST_WAIT   = 8'h08;
  localparam logic [7:0] ST_WRITE  = 8'h10;
  localparam logic [7:0] ST_DONE   = 8'h20;

  typedef struct packed {
    logic [1:0] ci;
    logic [1:0] co;
  } cfg_t;

  // Beats needed to load one plane for every input channel
  function automatic logic [3:0] beats_per_load(input logic [1:0] ci);
    logic [3:0] n_ch;
    n_ch = {2'b00, ci} + 4'd1;
    return 4'(n_ch * 4'(TAP_BEATS));
  endfunction

endpackage

// File: rtl/conv_sched_if.sv
// rtl/conv_sched_if.sv - control, load, MAC and result handshake bundle of the conv sequencer
interface conv_sched_if;
  import conv_pkg::*;

  logic              start_conv;
  logic [1:0]        cfg_ci;
  logic [1:0]        cfg_co;
  logic              in_valid;
  logic              read_w;
  logic              read_I;
  logic              ker_we;
  logic              win_we;
  logic [ADDR_W-1:0] buf_addr;
  logic              mac_start;
  logic              mac_done;
  logic              write_o;
  logic              o_ready;
  logic [1:0]        o_co;
  logic [1:0]        o_wx;
  logic [1:0]        o_wy;
  logic              end_conv;
  logic              busy;
  logic [7:0]        ostate;

  // Sequencer side
  modport master (
    input  start_conv, cfg_ci, cfg_co, in_valid, mac_done, o_ready,
    output read_w, read_I, ker_we, win_we, buf_addr, mac_start,
           write_o, o_co, o_wx, o_wy, end_conv, busy, ostate
  );

  // Datapath / host side
  modport slave (
    output start_conv, cfg_ci, cfg_co, in_valid, mac_done, o_ready,
    input  read_w, read_I, ker_we, win_we, buf_addr, mac_start,
           write_o, o_co, o_wx, o_wy, end_conv, busy, ostate
  );

endinterface

// File: rtl/conv_pos_cnt.sv
// rtl/conv_pos_cnt.sv - nested window x/y and output channel counter with last flags
module conv_pos_cnt
  import conv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       adv_i,
  input  logic [1:0] cfg_co_i,
  output logic [1:0] wx_o,
  output logic [1:0] wy_o,
  output logic [1:0] co_o,
  output logic       last_win_o,
  output logic       last_ch_o
);

  logic [1:0] wx_q, wx_d;
  logic [1:0] wy_q, wy_d;
  logic [1:0] co_q, co_d;

  assign last_win_o = (wx_q == 2'(N_WX - 1)) && (wy_q == 2'(N_WY - 1));
  assign last_ch_o  = (co_q == cfg_co_i);

  assign wx_o = wx_q;
  assign wy_o = wy_q;
  assign co_o = co_q;

  // Advance x first, carry into y, and into channel after the final window
  always_comb begin
    wx_d = wx_q;
    wy_d = wy_q;
    co_d = co_q;
    if (clr_i) begin
      wx_d = '0;
      wy_d = '0;
      co_d = '0;
    end else if (adv_i) begin
      if (wx_q == 2'(N_WX - 1)) begin
        wx_d = '0;
        if (wy_q == 2'(N_WY - 1)) begin
          wy_d = '0;
          if (!last_ch_o) co_d = co_q + 2'd1;
        end else begin
          wy_d = wy_q + 2'd1;
        end
      end else begin
        wx_d = wx_q + 2'd1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wx_q <= '0;
      wy_q <= '0;
      co_q <= '0;
    end else begin
      wx_q <= wx_d;
      wy_q <= wy_d;
      co_q <= co_d;
    end
  end

endmodule

// File: rtl/conv_sched.sv
// rtl/conv_sched.sv - kernel/window load, MAC trigger and result hand-off sequencer
module conv_sched
  import conv_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  conv_sched_if.master bus
);

  logic [7:0] state_q, state_d;
  logic [3:0] beat_q, beat_d;
  cfg_t       cfg_q, cfg_d;

  logic       cnt_clr;
  logic       cnt_adv;
  logic [1:0] wx, wy, co;
  logic       last_win, last_ch;
  logic [3:0] nb;
  logic       last_beat;

  assign nb        = beats_per_load(cfg_q.ci);
  assign last_beat = (beat_q == nb - 4'd1);

  conv_pos_cnt u_pos (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (cnt_clr),
    .adv_i      (cnt_adv),
    .cfg_co_i   (cfg_q.co),
    .wx_o       (wx),
    .wy_o       (wy),
    .co_o       (co),
    .last_win_o (last_win),
    .last_ch_o  (last_ch)
  );

  // Next-state, beat counter and config capture
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    cfg_d   = cfg_q;
    cnt_clr = 1'b0;
    cnt_adv = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_conv) begin
          cfg_d.ci = bus.cfg_ci;
          cfg_d.co = bus.cfg_co;
          beat_d   = '0;
          cnt_clr  = 1'b1;
          state_d  = ST_LD_KER;
        end
      end
      ST_LD_KER: begin
        if (bus.in_valid) begin
          if (last_beat) begin
            beat_d  = '0;
            state_d = ST_LD_WIN;
          end else begin
            beat_d = beat_q + 4'd1;
          end
        end
      end
      ST_LD_WIN: begin
        if (bus.in_valid) begin
          if (last_beat) begin
            beat_d  = '0;
            state_d = ST_MAC;
          end else begin
            beat_d = beat_q + 4'd1;
          end
        end
      end
      ST_MAC: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.mac_done) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (bus.o_ready) begin
          cnt_adv = 1'b1;
          if (!last_win)     state_d = ST_LD_WIN;
          else if (!last_ch) state_d = ST_LD_KER;
          else               state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, beat and captured config registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      cfg_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      cfg_q   <= cfg_d;
    end
  end

  // Strobes decode registered state only; the buffer write enables also qualify on in_valid
  assign bus.read_w    = (state_q == ST_LD_KER);
  assign bus.read_I    = (state_q == ST_LD_WIN);
  assign bus.ker_we    = (state_q == ST_LD_KER) && bus.in_valid;
  assign bus.win_we    = (state_q == ST_LD_WIN) && bus.in_valid;
  assign bus.buf_addr  = ADDR_W'(beat_q) * ADDR_W'(BEAT_BYTES);
  assign bus.mac_start = (state_q == ST_MAC);
  assign bus.write_o   = (state_q == ST_WRITE);
  assign bus.o_co      = co;
  assign bus.o_wx      = wx;
  assign bus.o_wy      = wy;
  assign bus.end_conv  = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.ostate    = state_q;

endmodule

// File: tb/tb_conv_sched.sv
// tb/tb_conv_sched.sv - directed self-checking bench for conv_sched
module tb_conv_sched;
  import conv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_sched_if bus();

  conv_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  bit mac_en   = 1'b1;
  bit tog_mode = 1'b0;

  int wr_co[$], wr_wx[$], wr_wy[$];
  int ker_addr[$], ker_at[$], win_addr[$];
  int we_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // MAC model: result valid for one cycle, the cycle after mac_start
  initial forever begin
    @(negedge clk);
    if (mac_en && bus.mac_start === 1'b1) begin
      @(posedge clk); #1 bus.mac_done = 1'b1;
      @(posedge clk); #1 bus.mac_done = 1'b0;
    end
  end

  // Alternating in_valid source
  initial forever begin
    @(posedge clk); #1;
    if (tog_mode) bus.in_valid = ~bus.in_valid;
  end

  // Observe accepted results and buffer writes mid-cycle
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (bus.write_o && bus.o_ready) begin
        wr_co.push_back(int'(bus.o_co));
        wr_wx.push_back(int'(bus.o_wx));
        wr_wy.push_back(int'(bus.o_wy));
      end
      if (bus.ker_we) begin
        ker_addr.push_back(int'(bus.buf_addr));
        ker_at.push_back(wr_co.size());
      end
      if (bus.win_we) win_addr.push_back(int'(bus.buf_addr));
      if (bus.win_we !== (bus.ostate == 8'h02 && bus.in_valid)) we_err++;
      if (bus.ker_we !== (bus.ostate == 8'h01 && bus.in_valid)) we_err++;
    end
  end

  task automatic clear_logs();
    wr_co.delete(); wr_wx.delete(); wr_wy.delete();
    ker_addr.delete(); ker_at.delete(); win_addr.delete();
    we_err = 0;
  endtask

  task automatic start_run(input logic [1:0] ci, input logic [1:0] co, output int t0);
    @(posedge clk); #1;
    bus.cfg_ci = ci; bus.cfg_co = co; bus.start_conv = 1'b1;
    @(posedge clk); #1;
    bus.start_conv = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_end(input int t0, output int n, output bit tmo);
    tmo = 1'b1; n = -1;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk); #1;
      if (bus.end_conv === 1'b1) begin n = cyc - t0; tmo = 1'b0; break; end
    end
  endtask

  task automatic wait_state(input logic [7:0] st, output bit tmo);
    tmo = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if (bus.ostate === st) begin tmo = 1'b0; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    total++; if (bus.ostate !== 8'h00) $display("FAIL reset_ostate got %h exp 00", bus.ostate); else passed++;
    total++; if ({bus.read_w, bus.read_I, bus.ker_we, bus.win_we, bus.mac_start, bus.write_o, bus.end_conv, bus.busy} !== 8'h00)
      $display("FAIL reset_strobes got %b exp 00000000", {bus.read_w, bus.read_I, bus.ker_we, bus.win_we, bus.mac_start, bus.write_o, bus.end_conv, bus.busy}); else passed++;
    total++; if ({bus.buf_addr, bus.o_co, bus.o_wx, bus.o_wy} !== 15'd0) $display("FAIL reset_addr_tags got %h exp 0", {bus.buf_addr, bus.o_co, bus.o_wx, bus.o_wy}); else passed++;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_single();
    int t0, n; bit tmo, bad;
    clear_logs();
    start_run(2'd0, 2'd0, t0);
    total++; if (bus.ostate !== 8'h01 || bus.read_w !== 1'b1) $display("FAIL single_ldker got %h/%b exp 01/1", bus.ostate, bus.read_w); else passed++;
    wait_end(t0, n, tmo);
    total++; if (tmo) $display("FAIL single_timeout got timeout exp end_conv"); else passed++;
    total++; if (n !== 82) $display("FAIL single_latency got %0d exp 82", n); else passed++;
    total++; if (wr_co.size() !== 16) $display("FAIL single_writes got %0d exp 16", wr_co.size()); else passed++;
    total++; if (ker_addr.size() !== 2 || ker_addr[0] !== 0 || ker_addr[1] !== 8) $display("FAIL single_ker got n=%0d exp 2 beats at 0,8", ker_addr.size()); else passed++;
    total++; if (win_addr.size() !== 32) $display("FAIL single_win got %0d exp 32", win_addr.size()); else passed++;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (wr_co[i] !== 0 || wr_wx[i] !== i % 4 || wr_wy[i] !== i / 4)
        $display("FAIL single_tag%0d got co%0d x%0d y%0d exp co0 x%0d y%0d", i, wr_co[i], wr_wx[i], wr_wy[i], i % 4, i / 4);
      else passed++;
    end
    bad = 1'b0;
    for (int i = 0; i < win_addr.size(); i++) if (win_addr[i] !== (i % 2) * 8) bad = 1'b1;
    total++; if (bad) $display("FAIL single_win_addr got bad sequence exp 0,8 repeating"); else passed++;
    @(posedge clk); #1;
    total++; if (bus.busy !== 1'b0 || bus.ostate !== 8'h00) $display("FAIL single_idle got busy%b st%h exp 0/00", bus.busy, bus.ostate); else passed++;
  endtask

  task automatic test_multi();
    int t0, n, bad; bit tmo;
    clear_logs();
    start_run(2'd3, 2'd1, t0);
    wait_end(t0, n, tmo);
    total++; if (tmo) $display("FAIL multi_timeout got timeout exp end_conv"); else passed++;
    total++; if (wr_co.size() !== 32) $display("FAIL multi_writes got %0d exp 32", wr_co.size()); else passed++;
    total++; if (ker_addr.size() !== 16) $display("FAIL multi_ker_beats got %0d exp 16", ker_addr.size()); else passed++;
    total++; if (ker_at[8] !== 16 || ker_at[7] !== 0) $display("FAIL multi_reload got at %0d/%0d exp 0/16", ker_at[7], ker_at[8]); else passed++;
    bad = 0;
    for (int i = 0; i < ker_addr.size(); i++) if (ker_addr[i] !== (i % 8) * 8) bad++;
    total++; if (bad !== 0) $display("FAIL multi_ker_addr got %0d bad exp 0", bad); else passed++;
    total++; if (win_addr.size() !== 256) $display("FAIL multi_win_beats got %0d exp 256", win_addr.size()); else passed++;
    bad = 0;
    for (int i = 0; i < win_addr.size(); i++) if (win_addr[i] !== (i % 8) * 8) bad++;
    total++; if (bad !== 0) $display("FAIL multi_win_addr got %0d bad exp 0", bad); else passed++;
    total++; if (win_addr[7] !== 56) $display("FAIL multi_max_addr got %0d exp 56", win_addr[7]); else passed++;
    bad = 0;
    for (int i = 0; i < 32; i++)
      if (wr_co[i] !== i / 16 || wr_wx[i] !== i % 4 || wr_wy[i] !== (i % 16) / 4) bad++;
    total++; if (bad !== 0) $display("FAIL multi_tags got %0d bad exp 0", bad); else passed++;
  endtask

  task automatic test_toggle();
    int t0, n, bad; bit tmo;
    clear_logs();
    tog_mode = 1'b1;
    start_run(2'd0, 2'd0, t0);
    wait_end(t0, n, tmo);
    tog_mode = 1'b0;
    bus.in_valid = 1'b1;
    total++; if (tmo) $display("FAIL toggle_timeout got timeout exp end_conv"); else passed++;
    total++; if (n <= 82) $display("FAIL toggle_latency got %0d exp >82", n); else passed++;
    total++; if (win_addr.size() !== 32) $display("FAIL toggle_win_beats got %0d exp 32", win_addr.size()); else passed++;
    total++; if (ker_addr.size() !== 2) $display("FAIL toggle_ker_beats got %0d exp 2", ker_addr.size()); else passed++;
    bad = 0;
    for (int i = 0; i < win_addr.size(); i++) if (win_addr[i] !== (i % 2) * 8) bad++;
    total++; if (bad !== 0) $display("FAIL toggle_win_addr got %0d bad exp 0", bad); else passed++;
    total++; if (we_err !== 0) $display("FAIL toggle_we_qual got %0d exp 0", we_err); else passed++;
    total++; if (wr_co.size() !== 16) $display("FAIL toggle_writes got %0d exp 16", wr_co.size()); else passed++;
  endtask

  task automatic test_stall();
    int t0, n; bit tmo;
    clear_logs();
    bus.o_ready = 1'b0;
    start_run(2'd0, 2'd0, t0);
    wait_state(8'h10, tmo);
    total++; if (tmo) $display("FAIL stall_reach got timeout exp WRITE"); else passed++;
    for (int k = 0; k < 10; k++) begin
      total++;
      if (bus.write_o !== 1'b1 || bus.ostate !== 8'h10 || bus.o_wx !== 2'd0 || bus.o_wy !== 2'd0 || bus.o_co !== 2'd0)
        $display("FAIL stall_hold%0d got w%b st%h x%0d y%0d exp 1/10/0/0", k, bus.write_o, bus.ostate, bus.o_wx, bus.o_wy);
      else passed++;
      @(posedge clk); #1;
    end
    bus.o_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.ostate !== 8'h02 || bus.o_wx !== 2'd1 || bus.write_o !== 1'b0) $display("FAIL stall_accept got st%h x%0d exp 02/1", bus.ostate, bus.o_wx); else passed++;
    wait_end(t0, n, tmo);
    total++; if (n !== 92) $display("FAIL stall_latency got %0d exp 92", n); else passed++;
    total++; if (wr_co.size() !== 16 || wr_wx[1] !== 1) $display("FAIL stall_writes got %0d exp 16", wr_co.size()); else passed++;
  endtask

  task automatic test_reset_mid();
    int t0, n; bit tmo;
    clear_logs();
    mac_en = 1'b0;
    start_run(2'd1, 2'd2, t0);
    wait_state(8'h08, tmo);
    total++; if (tmo) $display("FAIL rstmid_reach got timeout exp WAIT"); else passed++;
    #3 rst = 1'b1;
    #1;
    total++; if (bus.ostate !== 8'h00) $display("FAIL rstmid_ostate got %h exp 00", bus.ostate); else passed++;
    total++; if ({bus.read_w, bus.read_I, bus.ker_we, bus.win_we, bus.mac_start, bus.write_o, bus.end_conv, bus.busy} !== 8'h00)
      $display("FAIL rstmid_strobes got %b exp 00000000", {bus.read_w, bus.read_I, bus.ker_we, bus.win_we, bus.mac_start, bus.write_o, bus.end_conv, bus.busy}); else passed++;
    total++; if ({bus.buf_addr, bus.o_co, bus.o_wx, bus.o_wy} !== 15'd0) $display("FAIL rstmid_tags got %h exp 0", {bus.buf_addr, bus.o_co, bus.o_wx, bus.o_wy}); else passed++;
    @(posedge clk); #1 rst = 1'b0;
    mac_en = 1'b1;
    clear_logs();
    start_run(2'd0, 2'd0, t0);
    wait_end(t0, n, tmo);
    total++; if (n !== 82) $display("FAIL rstmid_rerun got %0d exp 82", n); else passed++;
    total++; if (wr_co.size() !== 16 || ker_addr.size() !== 2 || wr_wx[15] !== 3 || wr_wy[15] !== 3)
      $display("FAIL rstmid_rerun_seq got w%0d k%0d exp 16/2", wr_co.size(), ker_addr.size()); else passed++;
  endtask

  task automatic test_ignored();
    int t0, n; bit tmo;
    clear_logs();
    start_run(2'd0, 2'd0, t0);
    wait_state(8'h02, tmo);
    total++; if (tmo) $display("FAIL ign_reach got timeout exp LD_WIN"); else passed++;
    bus.start_conv = 1'b1; bus.mac_done = 1'b1; bus.cfg_ci = 2'd3; bus.cfg_co = 2'd3;
    @(posedge clk); #1;
    bus.start_conv = 1'b0; bus.mac_done = 1'b0;
    total++; if (bus.ostate !== 8'h02 || bus.buf_addr !== 9'd8) $display("FAIL ign_ldwin got st%h a%0d exp 02/8", bus.ostate, bus.buf_addr); else passed++;
    wait_end(t0, n, tmo);
    total++; if (n !== 82) $display("FAIL ign_latency got %0d exp 82", n); else passed++;
    total++; if (wr_co.size() !== 16 || ker_addr.size() !== 2 || win_addr.size() !== 32)
      $display("FAIL ign_counts got w%0d k%0d i%0d exp 16/2/32", wr_co.size(), ker_addr.size(), win_addr.size()); else passed++;
    bus.cfg_ci = 2'd0; bus.cfg_co = 2'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if (bus.busy !== 1'b0 || bus.ostate !== 8'h00) $display("FAIL ign_idle got busy%b st%h exp 0/00", bus.busy, bus.ostate); else passed++;
  endtask

  initial begin
    bus.start_conv = 1'b0; bus.cfg_ci = 2'd0; bus.cfg_co = 2'd0;
    bus.in_valid = 1'b1; bus.mac_done = 1'b0; bus.o_ready = 1'b1;
    test_reset();
    test_single();
    test_multi();
    test_toggle();
    test_stall();
    test_reset_mid();
    test_ignored();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
